// File: rtl/axilite_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes, width helpers
// and the read/write channel state types.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Number of address bits that select a byte within one bus word.
  function automatic int unsigned byte_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned reg_idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axilite_wr_ctrl.sv
// AXI4-Lite write channel control: independent AW/W capture, address decode and
// a one-cycle commit strobe that the register array consumes.
module axilite_wr_ctrl
  import axilite_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_SIZE  = 32,
  parameter int unsigned          NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
  localparam int unsigned         STRB_W     = DATA_WIDTH / 8,
  localparam int unsigned         IDX_W      = reg_idx_width(NUM_REGS)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_SIZE-1:0]  awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  commit_en,
  output logic [IDX_W-1:0]      commit_idx,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [STRB_W-1:0]     commit_strb
);

  localparam int unsigned OFF_W = byte_off_width(DATA_WIDTH);

  wr_state_e             state_q, state_d;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_SIZE-1:0]  aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q, resp_dec;
  logic [ADDR_SIZE-1:0]  aw_word;
  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_hs, w_hs, commit;

  assign bvalid  = (state_q == W_RESP);
  assign bresp   = bresp_q;
  assign awready = ~aw_held_q & ~bvalid;
  assign wready  = ~w_held_q & ~bvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  assign aw_word = aw_addr_q >> OFF_W;
  assign aw_idx  = aw_word[IDX_W-1:0];

  always_comb begin
    resp_dec = RESP_OKAY;
    if (aw_word >= ADDR_SIZE'(NUM_REGS)) begin
      resp_dec = RESP_DECERR;
    end else if (RO_MASK[aw_idx]) begin
      resp_dec = RESP_SLVERR;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          commit  = 1'b1;
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Ready is low while a channel is held, so a handshake never coincides with commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= awaddr;
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (commit) begin
        w_held_q <= 1'b0;
      end
      if (commit) bresp_q <= resp_dec;
    end
  end

  assign commit_en   = commit & (resp_dec == RESP_OKAY);
  assign commit_idx  = aw_idx;
  assign commit_data = w_data_q;
  assign commit_strb = w_strb_q;

endmodule

// File: rtl/axilite_regbank.sv
// Parametrised AXI4-Lite register bank with byte strobes, read-only status slots and
// decode errors. Define AXIL_REGBANK_WPULSE_EN to add the per-register wr_pulse output.
module axilite_regbank
  import axilite_pkg::*;
#(
  parameter int unsigned                     DATA_WIDTH  = 32,
  parameter int unsigned                     ADDR_SIZE   = 32,
  parameter int unsigned                     NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]             RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_SIZE-1:0]           awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_SIZE-1:0]           araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
`ifdef AXIL_REGBANK_WPULSE_EN
  ,
  output logic [NUM_REGS-1:0]            wr_pulse
`endif
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = byte_off_width(DATA_WIDTH);
  localparam int unsigned IDX_W  = reg_idx_width(NUM_REGS);

  logic                  commit_en;
  logic [IDX_W-1:0]      commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;
  logic [DATA_WIDTH-1:0] reg_word [NUM_REGS];

  axilite_wr_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_wr_ctrl (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_word[i] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          q <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (commit_en && (commit_idx == IDX_W'(i))) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (commit_strb[b]) q[8*b +: 8] <= commit_data[8*b +: 8];
          end
        end
      end
      assign reg_word[i] = q;
    end
    assign regs[i*DATA_WIDTH +: DATA_WIDTH] = reg_word[i];
  end

  // Read path: data is captured at the AR handshake edge, so a commit on the
  // same edge is not yet visible to it.
  rd_state_e             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_SIZE-1:0]  ar_word;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_decerr;

  assign ar_word   = araddr >> OFF_W;
  assign ar_idx    = ar_word[IDX_W-1:0];
  assign ar_decerr = (ar_word >= ADDR_SIZE'(NUM_REGS));

  always_comb begin
    rd_word = '0;
    if (!ar_decerr) begin
      rd_word = RO_MASK[ar_idx] ? status_in[ar_idx*DATA_WIDTH +: DATA_WIDTH] : reg_word[ar_idx];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_word;
          rresp_d    = ar_decerr ? RESP_DECERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

`ifdef AXIL_REGBANK_WPULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit_en && (|commit_strb)) wr_pulse_q[commit_idx] <= 1'b1;
    end
  end

  assign wr_pulse = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axilite_regbank.sv
// Directed bench for axilite_regbank: a vector table of single transactions plus
// hand-built sequences for channel skew, backpressure, same-edge access and reset.
module tb_axilite_regbank;

  logic         aclk, aresetn;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [255:0] regs, status_in;
`ifdef AXIL_REGBANK_WPULSE_EN
  logic [7:0]   wr_pulse;
  int           pulse_cnt = 0;
  always @(negedge aclk) if (wr_pulse != 8'h00) pulse_cnt++;
`endif

  int n_vec = 0;
  int n_err = 0;

  axilite_regbank #(
    .DATA_WIDTH  (32),
    .ADDR_SIZE   (32),
    .NUM_REGS    (8),
    .RO_MASK     (8'h80),
    .RESET_VALUE ('0)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .regs      (regs),
    .status_in (status_in)
`ifdef AXIL_REGBANK_WPULSE_EN
    ,
    .wr_pulse  (wr_pulse)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no handshake within 50 cycles, expected one", name);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int   cnt;
    logic aw_hs, w_hs;
    resp = 2'bxx;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    cnt = 0;
    while ((awvalid || wvalid) && cnt < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      cnt++;
    end
    if (awvalid || wvalid) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timed_out("write aw/w");
      return;
    end
    cnt = 0;
    while (!bvalid && cnt < 50) begin
      @(negedge aclk);
      cnt++;
    end
    if (!bvalid) begin
      timed_out("write b");
      return;
    end
    resp = bresp;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int cnt;
    d = 'x; resp = 2'bxx;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin
      @(negedge aclk);
      cnt++;
    end
    if (!arready) begin
      arvalid = 1'b0;
      timed_out("read ar");
      return;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid one cycle after ar", rvalid, 1);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] d;
    logic [1:0]  r;
`ifdef AXIL_REGBANK_WPULSE_EN
    int          pc0;
`endif

    aresetn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = '0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    check("reset bvalid", bvalid, 0);
    check("reset rvalid", rvalid, 0);
    check("reset bresp", bresp, 0);
    check("reset rresp", rresp, 0);
    check("reset rdata", rdata, 0);
    check("reset awready", awready, 1);
    check("reset wready", wready, 1);
    check("reset arready", arready, 1);
`ifdef AXIL_REGBANK_WPULSE_EN
    check("reset wr_pulse", wr_pulse, 0);
`endif

    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 32'(i * 4), 32'h0, 4'h0, 32'h0, 2'd0});
    vecs.push_back('{1'b0, 32'h08, 32'hDEADBEEF, 4'b0011, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 32'h08, 32'h0, 4'h0, 32'h0000BEEF, 2'd0});
    vecs.push_back('{1'b0, 32'h0C, 32'h11223344, 4'hF, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 32'h0C, 32'h0, 4'h0, 32'h11223344, 2'd0});
    vecs.push_back('{1'b0, 32'h0C, 32'hAABBCCDD, 4'b1000, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 32'h0C, 32'h0, 4'h0, 32'hAA223344, 2'd0});
    vecs.push_back('{1'b0, 32'h0C, 32'hFFFFFFFF, 4'b0000, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 32'h0C, 32'h0, 4'h0, 32'hAA223344, 2'd0});
    vecs.push_back('{1'b0, 32'h1C, 32'hFFFFFFFF, 4'hF, 32'h0, 2'd2});
    vecs.push_back('{1'b1, 32'h40, 32'h0, 4'h0, 32'h0, 2'd3});
    vecs.push_back('{1'b0, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 2'd3});
    vecs.push_back('{1'b1, 32'h3F, 32'h0, 4'h0, 32'h0, 2'd3});
    vecs.push_back('{1'b0, 32'h01, 32'h000000A5, 4'b0001, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 32'h00, 32'h0, 4'h0, 32'h000000A5, 2'd0});
    vecs.push_back('{1'b0, 32'h04, 32'h01020304, 4'b0110, 32'h0, 2'd0});
    vecs.push_back('{1'b1, 32'h04, 32'h0, 4'h0, 32'h00020300, 2'd0});

    foreach (vecs[k]) begin
      if (vecs[k].is_rd) begin
        axi_read(vecs[k].addr, d, r);
        check($sformatf("vec%0d rdata @%0h", k, vecs[k].addr), d, vecs[k].exp_data);
        check($sformatf("vec%0d rresp @%0h", k, vecs[k].addr), 32'(r), 32'(vecs[k].exp_resp));
      end else begin
        axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, r);
        check($sformatf("vec%0d bresp @%0h", k, vecs[k].addr), 32'(r), 32'(vecs[k].exp_resp));
      end
    end

    check("regs word0", regs[0 +: 32], 32'h000000A5);
    check("regs word1", regs[32 +: 32], 32'h00020300);
    check("regs word2", regs[64 +: 32], 32'h0000BEEF);
    check("regs word3", regs[96 +: 32], 32'hAA223344);
    check("regs word7 (RO)", regs[224 +: 32], 32'h0);

    // W three cycles ahead of AW, then B held off for several cycles.
    @(negedge aclk);
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    check("skew wready held", wready, 0);
    check("skew awready open", awready, 1);
    repeat (2) @(negedge aclk);
    awaddr = 32'h10; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    check("skew bvalid before commit", bvalid, 0);
    check("skew reg4 before commit", regs[128 +: 32], 32'h0);
    @(negedge aclk);
    check("skew bvalid at commit", bvalid, 1);
    check("skew bresp", bresp, 0);
    check("skew reg4 committed", regs[128 +: 32], 32'h0BADF00D);
`ifdef AXIL_REGBANK_WPULSE_EN
    check("skew wr_pulse", wr_pulse, 8'h10);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check($sformatf("hold%0d bvalid", i), bvalid, 1);
      check($sformatf("hold%0d bresp", i), bresp, 0);
      check($sformatf("hold%0d awready", i), awready, 0);
      check($sformatf("hold%0d wready", i), wready, 0);
`ifdef AXIL_REGBANK_WPULSE_EN
      check($sformatf("hold%0d wr_pulse", i), wr_pulse, 0);
`endif
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("after B bvalid", bvalid, 0);
    check("after B awready", awready, 1);
    check("after B wready", wready, 1);
    axi_write(32'h14, 32'h13579BDF, 4'hF, r);
    check("second write bresp", 32'(r), 0);
    axi_read(32'h14, d, r);
    check("second write readback", d, 32'h13579BDF);

    // Read-only slot returns live status, writes to it are refused.
    status_in[224 +: 32] = 32'h12345678;
    axi_read(32'h1C, d, r);
    check("RO rdata", d, 32'h12345678);
    check("RO rresp", 32'(r), 0);
`ifdef AXIL_REGBANK_WPULSE_EN
    pc0 = pulse_cnt;
`endif
    axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, r);
    check("RO bresp", 32'(r), 2);
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, r);
    check("DECERR bresp", 32'(r), 3);
    check("RO regs word7", regs[224 +: 32], 32'h0);
    check("DECERR regs word0", regs[0 +: 32], 32'h000000A5);
`ifdef AXIL_REGBANK_WPULSE_EN
    check("error writes wr_pulse count", pulse_cnt - pc0, 0);
`endif

    // Read accepted on the commit edge sees the old contents.
    @(negedge aclk);
    awaddr = 32'h18; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h18; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    check("same-edge rvalid", rvalid, 1);
    check("same-edge bvalid", bvalid, 1);
    check("same-edge rdata old", rdata, 32'h0);
    rready = 1'b1; bready = 1'b1;
    @(negedge aclk);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h18, d, r);
    check("same-edge readback", d, 32'hCAFEF00D);

    // Asynchronous reset with both responses pending.
    @(negedge aclk);
    awaddr = 32'h08; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    check("pre-reset bvalid", bvalid, 1);
    check("pre-reset rvalid", rvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("async reset bvalid", bvalid, 0);
    check("async reset rvalid", rvalid, 0);
    check("async reset rdata", rdata, 0);
    check("async reset reg2", regs[64 +: 32], 32'h0);
    check("async reset reg3", regs[96 +: 32], 32'h0);
    check("async reset reg6", regs[192 +: 32], 32'h0);
    check("async reset awready", awready, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    axi_write(32'h08, 32'h00000077, 4'hF, r);
    check("post-reset bresp", 32'(r), 0);
    axi_read(32'h08, d, r);
    check("post-reset rdata", d, 32'h00000077);
    check("post-reset rresp", 32'(r), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axilite_regbank.md
Name: axilite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-word cell register block.
- Generalises register count and data width; adds byte-strobe writes, per-register read-only/status mapping and address-decode error responses.
- Sits between the PS-side AXI-Lite interconnect and coprocessor datapath cells.
- Exposes the control registers as a flat vector and samples hardware status words for read-only slots.

Parameters:
- DATA_WIDTH, 32, bus/register width in bits (32 or 64).
- ADDR_SIZE, 32, AXI address width.
- NUM_REGS, 8, number of registers (1..256).
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only; reads return status_in word i.
- RESET_VALUE, {NUM_REGS*DATA_WIDTH{1'b0}}, reset contents of the writable registers.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_SIZE  write address.
- awvalid  in  1 / awready  out  1  AW handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wvalid  in  1 / wready  out  1  W handshake.
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response.
- araddr  in  ADDR_SIZE / arvalid  in  1 / arready  out  1  read address.
- rdata  out  DATA_WIDTH / rresp  out  2 / rvalid  out  1 / rready  in  1  read data.
- regs  out  NUM_REGS*DATA_WIDTH  register contents; word i at [i*DATA_WIDTH +: DATA_WIDTH].
- status_in  in  NUM_REGS*DATA_WIDTH  hardware status words; only RO slots are used.

Behaviour:
- Reset: applied asynchronously.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - AW/W holding registers are cleared.
  - Writable regs take RESET_VALUE; RO slots of regs read 0.
  - Any in-flight transaction is dropped, with no response.
- Address decode:
  - idx = addr[ADDR_SIZE-1:log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - idx >= NUM_REGS gives DECERR (3).
  - A write to an RO index gives SLVERR (2).
  - Everything else gives OKAY (0).
- Write path (states W_IDLE, W_RESP):
  - AW and W are accepted independently. awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
  - If both handshakes complete on edge N (or the second completes on edge N), the commit happens on edge N+1 and bvalid rises on edge N+1 with the decoded bresp.
  - Commit: for each byte b with wstrb[b]=1, reg[idx][8b+:8] is updated. On DECERR or SLVERR nothing is updated.
  - wstrb=0 with a valid address gives OKAY and no change.
  - bvalid/bresp are held until bready. Return to W_IDLE on the bvalid&bready edge.
  - A new AW/W may be accepted on the cycle after that edge.
- Read path (states R_IDLE, R_DATA):
  - arready = ~rvalid.
  - Handshake on edge N: rvalid=1 from edge N with rdata and rresp registered at that same edge.
  - rdata is the writable reg value, or status_in[idx] for an RO slot, or 0 on DECERR.
  - rdata/rresp/rvalid are held stable until rready.
  - Back-to-back reads are not overlapped: a new AR is accepted only after the rready handshake.
- Simultaneous read and write of the same register: a read accepted on the same edge as a commit returns the pre-commit value.
- Read and write paths are fully independent; neither stalls the other.
- No combinational path from any input valid/ready to any output ready/valid other than the hold flags above.

Optional Feature:
- Macro AXIL_REGBANK_WPULSE_EN.
- Defined:
  - Adds output wr_pulse [NUM_REGS]. Bit i is high for exactly one cycle, coincident with bvalid rising, when register i is committed with OKAY and at least one strobe set.
  - After reset it is 0. It never fires on SLVERR/DECERR or for RO slots.
- Undefined: the port is absent and no logic is generated.

Decomposition:
- Package axilite_pkg holds:
  - the RESP_OKAY/EXOKAY/SLVERR/DECERR constants (0..3);
  - the localparam function for byte-offset width;
  - the write-state and read-state enum typedefs.
- One sub-module, axilite_wr_ctrl: AW/W hold flags, W_IDLE/W_RESP FSM, decode and the commit-enable output.
- The read path and register array stay in the top.

Test Plan:
- Reset, then read all 8 regs (RESET_VALUE=0) → each rvalid one cycle after arready handshake, rdata=0, rresp=0.
- Write 0xDEADBEEF to addr 0x08 with wstrb=4'b0011, then read 0x08 → rdata=0x0000BEEF, bresp=0.
- W presented 3 cycles before AW, bready low for 4 cycles after bvalid → bvalid held with bresp stable; awready and wready low until the B handshake; a second write accepted the cycle after.
- RO_MASK=8'h80, status_in word 7=0x12345678: write 0x1C → bresp=2 and regs unchanged; read 0x1C → rdata=0x12345678, rresp=0.
- Read 0x40 and write 0x40 (NUM_REGS=8) → rresp=3, rdata=0, bresp=3, no register change; with AXIL_REGBANK_WPULSE_EN, wr_pulse stays 0.
- Deassert aresetn while bvalid=1 and rvalid=1 → both drop asynchronously, regs return to RESET_VALUE, and the first handshake after release completes normally.
